// File: rtl/mesh_term_tx.sv
// mesh_term_tx: terminal-side packet source for one mesh terminal.
// Buffers host packets with a per-packet delay, then presents each head packet
// to the router until the router consumes it with popin.
// Optional feature macro: MESH_TX_OVF_CNT_EN adds a saturating dropped-write counter.
module mesh_term_tx #(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int dly_w      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [pckg_sz-1:0]          din,
  input  logic [dly_w-1:0]            dly,
  output logic                        full,
  output logic [$clog2(fifo_depth):0] count,
  output logic [pckg_sz-1:0]          data_out_i_in,
  output logic                        pndng_i_in,
  input  logic                        popin,
  output logic                        overflow
`ifdef MESH_TX_OVF_CNT_EN
  ,
  output logic [15:0]                 ovf_cnt
`endif
);

  localparam int AW = $clog2(fifo_depth);
  localparam int CW = AW + 1;
  localparam int EW = dly_w + pckg_sz;

  typedef enum logic [1:0] {IDLE, WAIT, PRESENT} state_t;

  logic [EW-1:0]      mem [fifo_depth];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      rd_ptr_inc;
  logic [CW-1:0]      count_nxt;
  logic               at_full;
  logic               pop_acc;
  logic               push_acc;
  logic               push_drop;
  logic [EW-1:0]      head;
  logic [EW-1:0]      next_head;

  state_t             state;
  state_t             state_nxt;
  logic [dly_w-1:0]   dly_cnt;
  logic [dly_w-1:0]   dly_cnt_nxt;
  logic [pckg_sz-1:0] data_nxt;
  logic               load;
  logic [EW-1:0]      ld_entry;

  // A pop only counts while a packet is actually being presented; a pop at full frees
  // the slot so a same-cycle push is still accepted.
  assign at_full    = (count == CW'(fifo_depth));
  assign pop_acc    = popin && (state == PRESENT);
  assign push_acc   = push && (!at_full || pop_acc);
  assign push_drop  = push && at_full && !pop_acc;
  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign head       = mem[rd_ptr];
  assign next_head  = mem[rd_ptr_inc];
  assign pndng_i_in = (state == PRESENT);

  // Occupancy update from accepted push/pop.
  always_comb begin
    count_nxt = count;
    if (push_acc && !pop_acc)
      count_nxt = count + 1'b1;
    else if (!push_acc && pop_acc)
      count_nxt = count - 1'b1;
  end

  // Packet storage; entries need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_acc)
      mem[wr_ptr] <= {dly, din};
  end

  // Pointers, occupancy, full flag and the one-cycle overflow pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)
        rd_ptr <= rd_ptr_inc;
      count    <= count_nxt;
      full     <= (count_nxt == CW'(fifo_depth));
      overflow <= push_drop;
    end
  end

  // Next-state logic: whenever a new head is taken up, a zero delay goes straight to
  // PRESENT; otherwise WAIT counts down from dly-1 so the packet appears dly+1 cycles
  // after it was written into an empty buffer.
  always_comb begin
    state_nxt   = state;
    dly_cnt_nxt = dly_cnt;
    data_nxt    = data_out_i_in;
    load        = 1'b0;
    ld_entry    = head;
    case (state)
      IDLE: begin
        if (count != '0) begin
          load     = 1'b1;
          ld_entry = head;
        end
      end
      WAIT: begin
        if (dly_cnt == '0) begin
          state_nxt = PRESENT;
          data_nxt  = head[pckg_sz-1:0];
        end else begin
          dly_cnt_nxt = dly_cnt - 1'b1;
        end
      end
      PRESENT: begin
        if (pop_acc) begin
          if (count > CW'(1)) begin
            load     = 1'b1;
            ld_entry = next_head;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) begin
      if (ld_entry[EW-1 -: dly_w] == '0) begin
        state_nxt = PRESENT;
        data_nxt  = ld_entry[pckg_sz-1:0];
      end else begin
        state_nxt   = WAIT;
        dly_cnt_nxt = ld_entry[EW-1 -: dly_w] - 1'b1;
      end
    end
  end

  // FSM state, delay counter and the registered packet toward the router.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      dly_cnt       <= '0;
      data_out_i_in <= '0;
    end else begin
      state         <= state_nxt;
      dly_cnt       <= dly_cnt_nxt;
      data_out_i_in <= data_nxt;
    end
  end

`ifdef MESH_TX_OVF_CNT_EN
  // Saturating count of dropped host writes, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ovf_cnt <= '0;
    else if (push_drop && (ovf_cnt != 16'hFFFF))
      ovf_cnt <= ovf_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mesh_term_tx.sv
// tb_mesh_term_tx: directed self-checking bench for mesh_term_tx (default parameters).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mesh_term_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push = 1'b0;
  logic [39:0] din = '0;
  logic [7:0]  dly = '0;
  logic        popin = 1'b0;
  logic        full;
  logic [2:0]  count;
  logic [39:0] data_out_i_in;
  logic        pndng_i_in;
  logic        overflow;
`ifdef MESH_TX_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [39:0] expData;

  mesh_term_tx #(.pckg_sz(40), .fifo_depth(4), .dly_w(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .din           (din),
    .dly           (dly),
    .full          (full),
    .count         (count),
    .data_out_i_in (data_out_i_in),
    .pndng_i_in    (pndng_i_in),
    .popin         (popin),
    .overflow      (overflow)
`ifdef MESH_TX_OVF_CNT_EN
    ,
    .ovf_cnt       (ovf_cnt)
`endif
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic p, input logic [39:0] d, input logic [7:0] dl,
                               input logic pop);
    push  = p;
    din   = d;
    dly   = dl;
    popin = pop;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset state
    applyStimulus(1'b0, '0, '0, 1'b0);
    tick(2);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_pndng", 64'(pndng_i_in), 64'd0);
    checkOutput("rst_full", 64'(full), 64'd0);
    checkOutput("rst_ovf", 64'(overflow), 64'd0);
    checkOutput("rst_data", 64'(data_out_i_in), 64'd0);
`ifdef MESH_TX_OVF_CNT_EN
    checkOutput("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
`endif
    reset = 1'b1;
    tick();

    // 1: dly=0 packet appears one cycle after the write, held stable, then popped
    applyStimulus(1'b1, 40'h01_0000_00AA, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("t1_count1", 64'(count), 64'd1);
    checkOutput("t1_pndng_early", 64'(pndng_i_in), 64'd0);
    tick();
    checkOutput("t1_pndng", 64'(pndng_i_in), 64'd1);
    checkOutput("t1_data", 64'(data_out_i_in), 64'h01_0000_00AA);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("t1_hold_pndng", 64'(pndng_i_in), 64'd1);
      checkOutput("t1_hold_data", 64'(data_out_i_in), 64'h01_0000_00AA);
    end
    applyStimulus(1'b0, '0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("t1_pop_count", 64'(count), 64'd0);
    checkOutput("t1_pop_pndng", 64'(pndng_i_in), 64'd0);

    // 2: dly=5 -> low for 5 cycles after the write, high on the 6th
    applyStimulus(1'b1, 40'h02_0000_0055, 8'd5, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOutput("t2_wait_pndng", 64'(pndng_i_in), 64'd0);
    end
    tick();
    checkOutput("t2_pndng", 64'(pndng_i_in), 64'd1);
    checkOutput("t2_data", 64'(data_out_i_in), 64'h02_0000_0055);
    applyStimulus(1'b0, '0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("t2_pop_pndng", 64'(pndng_i_in), 64'd0);
    checkOutput("t2_pop_count", 64'(count), 64'd0);

    // 3: five writes into a depth-4 buffer, fifth dropped with an overflow pulse
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 40'h03_0000_0000 | 40'(k), 8'd0, 1'b0);
      tick();
      if (k <= 4) begin
        checkOutput("t3_count", 64'(count), 64'(k));
        checkOutput("t3_ovf_low", 64'(overflow), 64'd0);
      end
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("t3_ovf_pulse", 64'(overflow), 64'd1);
    checkOutput("t3_full", 64'(full), 64'd1);
    checkOutput("t3_count_full", 64'(count), 64'd4);
    tick();
    checkOutput("t3_ovf_end", 64'(overflow), 64'd0);
`ifdef MESH_TX_OVF_CNT_EN
    checkOutput("t3_ovf_cnt", 64'(ovf_cnt), 64'd1);
`endif
    for (int k = 1; k <= 4; k++) begin
      expData = 40'h03_0000_0000 | 40'(k);
      checkOutput("t3_pop_pndng", 64'(pndng_i_in), 64'd1);
      checkOutput("t3_pop_data", 64'(data_out_i_in), 64'(expData));
      applyStimulus(1'b0, '0, '0, 1'b1);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0);
    end
    checkOutput("t3_empty_count", 64'(count), 64'd0);
    checkOutput("t3_empty_full", 64'(full), 64'd0);
    tick(2);
    checkOutput("t3_no_fifth", 64'(pndng_i_in), 64'd0);

    // 4: push and pop in the same cycle at full
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 40'h04_0000_0000 | 40'(k), 8'd0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    tick();
    checkOutput("t4_full", 64'(full), 64'd1);
    checkOutput("t4_head", 64'(data_out_i_in), 64'h04_0000_0001);
    applyStimulus(1'b1, 40'h04_0000_0005, 8'd0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("t4_no_ovf", 64'(overflow), 64'd0);
    checkOutput("t4_count", 64'(count), 64'd4);
    checkOutput("t4_full_kept", 64'(full), 64'd1);
    for (int k = 2; k <= 5; k++) begin
      expData = 40'h04_0000_0000 | 40'(k);
      checkOutput("t4_order", 64'(data_out_i_in), 64'(expData));
      applyStimulus(1'b0, '0, '0, 1'b1);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0);
    end
    checkOutput("t4_empty", 64'(count), 64'd0);

    // 5: three refills of four dly=0 packets, drained one per cycle with popin held
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 4; k++) begin
        applyStimulus(1'b1, 40'h05_0000_0000 | 40'(r * 4 + k), 8'd0, 1'b0);
        tick();
      end
      applyStimulus(1'b0, '0, '0, 1'b1);
      for (int k = 1; k <= 4; k++) begin
        expData = 40'h05_0000_0000 | 40'(r * 4 + k);
        checkOutput("t5_pndng", 64'(pndng_i_in), 64'd1);
        checkOutput("t5_data", 64'(data_out_i_in), 64'(expData));
        tick();
      end
      applyStimulus(1'b0, '0, '0, 1'b0);
      checkOutput("t5_drained", 64'(count), 64'd0);
      checkOutput("t5_idle", 64'(pndng_i_in), 64'd0);
    end

    // 6: asynchronous reset while waiting with three entries
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 40'h06_0000_0000 | 40'(k), 8'd20, 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    tick(2);
    checkOutput("t6_wait_pndng", 64'(pndng_i_in), 64'd0);
    checkOutput("t6_wait_count", 64'(count), 64'd3);
    reset = 1'b0;
    #2;
    checkOutput("t6_async_count", 64'(count), 64'd0);
    checkOutput("t6_async_pndng", 64'(pndng_i_in), 64'd0);
    checkOutput("t6_async_data", 64'(data_out_i_in), 64'd0);
    checkOutput("t6_async_full", 64'(full), 64'd0);
`ifdef MESH_TX_OVF_CNT_EN
    checkOutput("t6_async_ovf_cnt", 64'(ovf_cnt), 64'd0);
`endif
    tick();
    reset = 1'b1;
    tick();
    checkOutput("t6_post_count", 64'(count), 64'd0);
    applyStimulus(1'b0, '0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("t6_idle_pop_count", 64'(count), 64'd0);
    checkOutput("t6_idle_pop_pndng", 64'(pndng_i_in), 64'd0);
    applyStimulus(1'b1, 40'h06_0000_00FF, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0);
    tick();
    checkOutput("t6_after_pndng", 64'(pndng_i_in), 64'd1);
    checkOutput("t6_after_data", 64'(data_out_i_in), 64'h06_0000_00FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
